ins_fetch: RTL and testbench

Instruction fetch and cycle sequencer for the teaching CPU. It owns the program counter and instruction register, reads instruction bytes from synchronous program memory, and drives the 4-bit opcode `ir` and decode enable `en` into the instruction decoder. It consumes the decoder's `jmp`, `jg`, `movi` and `halt` strobes to fetch second operand bytes, redirect the PC, or stop the machine.

---
 rtl/ins_fetch_if.sv | 13 +
 rtl/ins_fetch.sv | 138 +++++++++++++
 tb/tb_ins_fetch.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ins_fetch_if.sv
// Program-memory read bus: the fetch unit is the master, synchronous program memory the slave.
// Read data appears on mem_data one cycle after a cycle with mem_rd high.
interface ins_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;

  modport master (output mem_addr, output mem_rd, input mem_data);
  modport slave  (input mem_addr, input mem_rd, output mem_data);
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch and cycle sequencer: owns PC and IR, fetches one- and two-byte
// instructions from program memory and reacts to the decoder's jmp/jg/movi/halt strobes.
module ins_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  ins_fetch_if.master       mem,
  output logic [3:0]        ir,
  output logic [3:0]        rf,
  output logic              en,
  input  logic              jmp,
  input  logic              jg,
  input  logic              movi,
  input  logic              halt,
  input  logic              flag_g,
  output logic [DATA_W-1:0] opr,
  output logic              opr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_DECODE, S_OPFETCH, S_OPLOAD, S_HALT
  } state_e;

  typedef enum logic [1:0] {K_NONE, K_JMP, K_JG, K_MOVI} kind_e;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_e            state_q;
  kind_e             kind_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q;
  logic [3:0]        ir_q;
  logic [3:0]        rf_q;
  logic              en_q;
  logic [DATA_W-1:0] opr_q;
  logic              opr_valid_q;
  logic              busy_q;
  logic              halted_q;

  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] pc_opload_d;

  // Operand byte is truncated or zero-extended to the PC width.
  assign jump_target = ADDR_W'(mem.mem_data);

  always_comb begin
    pc_opload_d = pc_q + PC_ONE;
    if (kind_q == K_JMP || (kind_q == K_JG && flag_g)) begin
      pc_opload_d = jump_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      kind_q      <= K_NONE;
      pc_q        <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      ir_q        <= '0;
      rf_q        <= '0;
      en_q        <= 1'b0;
      opr_q       <= '0;
      opr_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      // Pulsed outputs are asserted on the edge entering the state that shows them.
      en_q        <= 1'b0;
      mem_rd_q    <= 1'b0;
      opr_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_FETCH;
            mem_addr_q <= pc_q;
            mem_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          ir_q    <= mem.mem_data[7:4];
          rf_q    <= mem.mem_data[3:0];
          pc_q    <= pc_q + PC_ONE;
          en_q    <= 1'b1;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (halt) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else if (jmp || jg || movi) begin
            kind_q     <= jmp ? K_JMP : (jg ? K_JG : K_MOVI);
            state_q    <= S_OPFETCH;
            mem_addr_q <= pc_q;
            mem_rd_q   <= 1'b1;
          end else begin
            state_q    <= S_FETCH;
            mem_addr_q <= pc_q;
            mem_rd_q   <= 1'b1;
          end
        end
        S_OPFETCH: state_q <= S_OPLOAD;
        S_OPLOAD: begin
          opr_q       <= mem.mem_data;
          opr_valid_q <= (kind_q == K_MOVI);
          pc_q        <= pc_opload_d;
          mem_addr_q  <= pc_opload_d;
          mem_rd_q    <= 1'b1;
          state_q     <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_rd   = mem_rd_q;
  assign ir           = ir_q;
  assign rf           = rf_q;
  assign en           = en_q;
  assign opr          = opr_q;
  assign opr_valid    = opr_valid_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: small programs in a behavioural memory, a decoder model,
// and scoreboard queues of expected fetch addresses, decode events and movi operands.
module tb_ins_fetch;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic flag_g = 1'b0;
  logic jmp, jg, movi, halt;
  logic [3:0] ir, rf;
  logic en, opr_valid, busy, halted;
  logic [DATA_W-1:0] opr;
  logic [ADDR_W-1:0] pc;

  ins_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ins_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mem(bus),
    .ir(ir), .rf(rf), .en(en),
    .jmp(jmp), .jg(jg), .movi(movi), .halt(halt), .flag_g(flag_g),
    .opr(opr), .opr_valid(opr_valid), .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // Decoder model: strobes follow ir at all times, so they are also present outside DECODE.
  assign jmp  = (ir == 4'hA);
  assign jg   = (ir == 4'hB);
  assign movi = (ir == 4'h2);
  assign halt = (ir == 4'h3);

  logic [7:0] prog [256];
  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= prog[bus.mem_addr];

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [7:0]  exp_addr [$];
  logic [15:0] exp_en [$];
  logic [7:0]  exp_opr [$];
  int          en_cyc [$];
  int          rd_cyc [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every DUT read, decode pulse and operand pulse must be expected.
  always @(negedge clk) begin
    if (bus.mem_rd === 1'b1) begin
      rd_cyc.push_back(pcyc);
      check("rd_pending", 32'(exp_addr.size() > 0), 32'd1);
      if (exp_addr.size() > 0) check("fetch_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
    end
    if (en === 1'b1) begin
      en_cyc.push_back(pcyc);
      check("en_pending", 32'(exp_en.size() > 0), 32'd1);
      if (exp_en.size() > 0) check("decode_ir_rf_pc", 32'({ir, rf, pc}), 32'(exp_en.pop_front()));
    end
    if (opr_valid === 1'b1) begin
      check("opr_pending", 32'(exp_opr.size() > 0), 32'd1);
      check("opr_valid_with_fetch", 32'(bus.mem_rd), 32'd1);
      if (exp_opr.size() > 0) check("movi_opr", 32'(opr), 32'(exp_opr.pop_front()));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic begin_test();
    do_reset();
    exp_addr.delete();
    exp_en.delete();
    exp_opr.delete();
    en_cyc.delete();
    rd_cyc.delete();
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
  endtask

  task automatic start_prog(output int s0);
    @(negedge clk);
    start = 1'b1;
    s0 = pcyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (halted === 1'b1) break;
      @(negedge clk);
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  task automatic drain(input string tag);
    check({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
    check({tag, "_en_left"}, 32'(exp_en.size()), 32'd0);
    check({tag, "_opr_left"}, 32'(exp_opr.size()), 32'd0);
  endtask

  initial begin
    int s0;
    bit found;

    // Reset state
    begin_test();
    check("rst_regs", 32'({pc, ir, rf, opr}), 32'd0);
    check("rst_flags", 32'({bus.mem_addr, en, bus.mem_rd, opr_valid, busy, halted}), 32'd0);

    // Two one-byte instructions then halt: en at 3 and 6 cycles after start
    begin_test();
    prog[0] = 8'h81; prog[1] = 8'h45; prog[2] = 8'h30;
    exp_addr = '{8'h00, 8'h01, 8'h02};
    exp_en   = '{16'h8101, 16'h4502, 16'h3003};
    start_prog(s0);
    check("busy_in_fetch", 32'(busy), 32'd1);
    wait_halt("t1_halt");
    drain("t1");
    check("t1_en0_cycle", 32'(en_cyc[0] - s0), 32'd3);
    check("t1_en1_cycle", 32'(en_cyc[1] - s0), 32'd6);

    // jmp 0x40
    begin_test();
    prog[0] = 8'hA0; prog[1] = 8'h40; prog[8'h40] = 8'h80; prog[8'h41] = 8'h30;
    exp_addr = '{8'h00, 8'h01, 8'h40, 8'h41};
    exp_en   = '{16'hA001, 16'h8041, 16'h3042};
    start_prog(s0);
    wait_halt("t2_halt");
    drain("t2");
    check("t2_fetch_to_fetch", 32'(rd_cyc[2] - rd_cyc[0]), 32'd5);

    // jg taken
    begin_test();
    flag_g = 1'b1;
    prog[0] = 8'hB0; prog[1] = 8'h10; prog[2] = 8'h30; prog[8'h10] = 8'h30;
    exp_addr = '{8'h00, 8'h01, 8'h10};
    exp_en   = '{16'hB001, 16'h3011};
    start_prog(s0);
    wait_halt("t3_halt");
    drain("t3");

    // jg not taken
    begin_test();
    flag_g = 1'b0;
    prog[0] = 8'hB0; prog[1] = 8'h10; prog[2] = 8'h30; prog[8'h10] = 8'h30;
    exp_addr = '{8'h00, 8'h01, 8'h02};
    exp_en   = '{16'hB001, 16'h3003};
    start_prog(s0);
    wait_halt("t4_halt");
    drain("t4");

    // movi 0x5A
    begin_test();
    prog[0] = 8'h23; prog[1] = 8'h5A; prog[2] = 8'h30;
    exp_addr = '{8'h00, 8'h01, 8'h02};
    exp_en   = '{16'h2301, 16'h3003};
    exp_opr  = '{8'h5A};
    start_prog(s0);
    wait_halt("t5_halt");
    drain("t5");
    check("t5_opr_held", 32'(opr), 32'h5A);

    // halt: halted the cycle after DECODE, start ignored, rst recovers
    begin_test();
    prog[0] = 8'h30;
    exp_addr = '{8'h00};
    exp_en   = '{16'h3001};
    start_prog(s0);
    repeat (2) @(negedge clk);
    check("t6_decode_not_halted", 32'({en, halted}), 32'b10);
    @(negedge clk);
    check("t6_halted_busy", 32'({halted, busy, en, bus.mem_rd}), 32'b1000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_start_ignored", 32'({halted, busy, pc}), 32'({1'b1, 1'b0, 8'h01}));
    drain("t6");
    do_reset();
    check("t6_after_rst", 32'({halted, busy, pc}), 32'd0);

    // PC wrap: jmp 0xFF, halt there leaves pc at 0x00
    begin_test();
    prog[0] = 8'hA0; prog[1] = 8'hFF; prog[8'hFF] = 8'h30;
    exp_addr = '{8'h00, 8'h01, 8'hFF};
    exp_en   = '{16'hA001, 16'h3000};
    start_prog(s0);
    wait_halt("t7_halt");
    drain("t7");
    check("t7_pc_wrap", 32'(pc), 32'h00);

    // Reset during OPFETCH
    begin_test();
    prog[0] = 8'hA0; prog[1] = 8'h40;
    exp_addr = '{8'h00, 8'h01};
    exp_en   = '{16'hA001};
    start_prog(s0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_rd === 1'b1 && bus.mem_addr === 8'h01) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t8_reached_opfetch", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t8_rst_regs", 32'({pc, ir, rf, opr}), 32'd0);
    check("t8_rst_flags", 32'({bus.mem_addr, en, bus.mem_rd, opr_valid, busy, halted}), 32'd0);
    repeat (4) @(negedge clk);
    check("t8_stays_idle", 32'({busy, halted, pc}), 32'd0);
    drain("t8");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
